sar_seq: RTL and testbench

//   Synchronous SAR conversion sequencer for the 9-bit SAR ADC; sits directly upstream of the CDAC switch controller.

---
 rtl/sar_seq.sv | 150 +++++++++++++++
 tb/tb_sar_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq.sv
// SAR conversion sequencer: sample strobe, comparator clock and per-bit capture
// strobes for an NBIT SAR ADC; MSB-first, finished code on DOUT with DVALID.
module sar_seq #(
  parameter int NBIT        = 9,
  parameter int SAMPLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 7
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            EN,
  input  logic            CMP_P,
  input  logic            CMP_N,
  output logic            CKSB,
  output logic            CKC,
  output logic [NBIT-1:0] CF,
  output logic [NBIT-1:0] DOUT,
  output logic            DVALID,
  output logic            BUSY,
  output logic            TOUT
);
  localparam int CMAX = (SAMPLE_CYC > TIMEOUT_CYC) ? SAMPLE_CYC : TIMEOUT_CYC;
  localparam int TW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (NBIT > 1) ? $clog2(NBIT) : 1;

  typedef enum logic [2:0] {IDLE, SAMPLE, COMP, LATCH, RELEASE, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      p_sync, n_sync;
  logic            p_s, n_s, dec, clr, to_hit;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic            tf, tf_nx;
  logic [BW-1:0]   b, b_nx;
  logic [NBIT-1:0] code, code_nx;
  logic            cksb_nx, ckc_nx, dvalid_nx, busy_nx, tout_nx;
  logic [NBIT-1:0] cf_nx, dout_nx;

  assign p_s    = p_sync[1];
  assign n_s    = n_sync[1];
  assign dec    = p_s ^ n_s;
  assign clr    = ~p_s & ~n_s;
  assign to_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      p_sync <= '0;
      n_sync <= '0;
      tcnt   <= '0;
      tf     <= 1'b0;
      b      <= '0;
      code   <= '0;
      CKSB   <= 1'b0;
      CKC    <= 1'b0;
      CF     <= '0;
      DOUT   <= '0;
      DVALID <= 1'b0;
      BUSY   <= 1'b0;
      TOUT   <= 1'b0;
    end else begin
      state  <= state_nx;
      p_sync <= {p_sync[0], CMP_P};
      n_sync <= {n_sync[0], CMP_N};
      tcnt   <= tcnt_nx;
      tf     <= tf_nx;
      b      <= b_nx;
      code   <= code_nx;
      CKSB   <= cksb_nx;
      CKC    <= ckc_nx;
      CF     <= cf_nx;
      DOUT   <= dout_nx;
      DVALID <= dvalid_nx;
      BUSY   <= busy_nx;
      TOUT   <= tout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    tf_nx    = tf;
    b_nx     = b;
    code_nx  = code;
    unique case (state)
      IDLE, DONE: begin
        if (EN) begin
          state_nx = SAMPLE;
          tcnt_nx  = '0;
          tf_nx    = 1'b0;
          b_nx     = BW'(NBIT - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      SAMPLE: begin
        if (tcnt == TW'(SAMPLE_CYC - 1)) begin
          state_nx = COMP;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      COMP: begin
        // A timed-out decision latches whatever P_s holds (0 when the comparator never fired)
        if (dec || to_hit) begin
          state_nx   = LATCH;
          tcnt_nx    = '0;
          code_nx[b] = p_s;
          if (!dec) tf_nx = 1'b1;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      LATCH: begin
        state_nx = RELEASE;
        tcnt_nx  = '0;
      end
      RELEASE: begin
        if (clr || to_hit) begin
          tcnt_nx = '0;
          if (!clr) tf_nx = 1'b1;
          if (b == '0) begin
            state_nx = DONE;
          end else begin
            b_nx     = b - 1'b1;
            state_nx = COMP;
          end
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop
  always_comb begin
    cksb_nx   = (state_nx == COMP) || (state_nx == LATCH) || (state_nx == RELEASE);
    ckc_nx    = (state_nx == COMP) || (state_nx == LATCH);
    cf_nx     = CF;
    if (!cksb_nx)
      cf_nx = '0;
    else if (state == COMP && state_nx == LATCH)
      cf_nx[b] = 1'b1;
    dvalid_nx = (state_nx == DONE);
    dout_nx   = dvalid_nx ? code_nx : DOUT;
    tout_nx   = dvalid_nx ? tf_nx : TOUT;
    busy_nx   = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_sar_seq.sv
// Self-checking bench for sar_seq: behavioural comparator model driven by CKC,
// expected codes/flags derived from the stimulus code and the injected fault.
module tb_sar_seq;
  localparam int NBIT        = 9;
  localparam int SAMPLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 7;
  localparam int BIT_CYC     = 7;
  localparam int LAT         = 1 + SAMPLE_CYC + BIT_CYC * NBIT - 1;

  logic            CLK = 1'b0, RSTN = 1'b0, EN = 1'b0, CMP_P = 1'b0, CMP_N = 1'b0;
  logic            CKSB, CKC, DVALID, BUSY, TOUT;
  logic [NBIT-1:0] CF, DOUT;

  int n_chk = 0, n_fail = 0;

  sar_seq #(.NBIT(NBIT), .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .CMP_P(CMP_P), .CMP_N(CMP_N),
    .CKSB(CKSB), .CKC(CKC), .CF(CF), .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY), .TOUT(TOUT)
  );

  always #5 CLK = ~CLK;

  // Comparator: resolves the current code's bit on each CKC rise, resets on CKC fall
  logic [NBIT-1:0] code_q[$];
  logic [NBIT-1:0] cur_code = '0;
  int   mbit = NBIT - 1;
  int   nodec_bit = -1, stuck_bit = -1;
  logic model_rst = 1'b1, ckc_prev = 1'b0;

  always @(CKC or model_rst) begin
    #1;
    if (model_rst) begin
      mbit = NBIT - 1; CMP_P = 1'b0; CMP_N = 1'b0; ckc_prev = 1'b0;
    end else if (CKC && !ckc_prev) begin
      ckc_prev = 1'b1;
      if (mbit == NBIT - 1) cur_code = (code_q.size() > 0) ? code_q.pop_front() : '0;
      if (mbit == nodec_bit) begin
        CMP_P = 1'b0; CMP_N = 1'b0;
      end else begin
        CMP_P = cur_code[mbit]; CMP_N = ~cur_code[mbit];
      end
    end else if (!CKC && ckc_prev) begin
      ckc_prev = 1'b0;
      CMP_P = (mbit == stuck_bit); CMP_N = 1'b0;
      mbit = (mbit == 0) ? NBIT - 1 : mbit - 1;
    end
  end

  int rises, viol, low_cyc;
  int rise_at[NBIT];

  task automatic do_reset();
    model_rst = 1'b1; RSTN = 1'b0; EN = 1'b0;
    nodec_bit = -1; stuck_bit = -1; code_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK); RSTN = 1'b1; model_rst = 1'b0;
  endtask

  // Cycle k is the edge k after the one that first samples EN (k0 = first index)
  task automatic watch(input int k0, input int drop_at, input int max_cyc, output int dv_at);
    logic [NBIT-1:0] prev_cf;
    dv_at = -1; rises = 0; viol = 0; low_cyc = 0; prev_cf = CF;
    for (int i = 0; i < NBIT; i++) rise_at[i] = -1;
    for (int k = k0; k < k0 + max_cyc && dv_at < 0; k++) begin
      @(posedge CLK); #1;
      if (k == drop_at) EN = 1'b0;
      if ($countones(CF & ~prev_cf) > 1) viol++;
      if (!CKSB && CF != '0) viol++;
      for (int i = 0; i < NBIT; i++) begin
        if (CF[i] && !prev_cf[i]) begin rises++; rise_at[i] = k; end
        if (i < NBIT - 1 && CF[i] && !CF[i+1]) viol++;
      end
      if (!CKSB && !DVALID) low_cyc++;
      prev_cf = CF;
      if (DVALID) dv_at = k;
    end
  endtask

  task automatic test_reset();
    int dv;
    logic [NBIT-1:0] c;
    n_chk++; if ({CKSB, CKC, CF, DOUT, DVALID, BUSY, TOUT} !== '0) begin
      n_fail++; $display("FAIL reset_state: got %b expected all zero", {CKSB, CKC, CF, DOUT, DVALID, BUSY, TOUT});
    end
    do_reset();
    c = NBIT'($urandom);
    code_q.push_back(c);
    @(negedge CLK); EN = 1'b1;
    @(posedge CLK); #1; EN = 1'b0;
    repeat (SAMPLE_CYC + BIT_CYC * 3 + 1) @(posedge CLK);
    #2;
    n_chk++; if (CKC !== 1'b1 || CF !== 9'h1C0) begin
      n_fail++; $display("FAIL reset_pre_bit5: CKC=%b CF=%h expected CKC=1 CF=1c0", CKC, CF);
    end
    RSTN = 1'b0; #1;
    n_chk++; if (CKSB !== 1'b0 || CKC !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_clk: CKSB=%b CKC=%b expected 0 0", CKSB, CKC);
    end
    n_chk++; if (CF !== '0 || BUSY !== 1'b0 || DOUT !== '0 || DVALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_out: CF=%h BUSY=%b DOUT=%h DVALID=%b expected zeros", CF, BUSY, DOUT, DVALID);
    end
    do_reset();
    watch(0, 0, 100, dv);
    n_chk++; if (dv !== -1 || DOUT !== '0) begin
      n_fail++; $display("FAIL reset_no_dvalid: dv_at=%0d DOUT=%h expected -1 000", dv, DOUT);
    end
  endtask

  task automatic test_single(input logic [NBIT-1:0] c);
    int dv;
    code_q.push_back(c);
    @(negedge CLK); EN = 1'b1;
    watch(0, 0, 200, dv);
    n_chk++; if (dv !== LAT) begin
      n_fail++; $display("FAIL single_latency: got %0d expected %0d", dv, LAT);
    end
    n_chk++; if (DOUT !== c || TOUT !== 1'b0) begin
      n_fail++; $display("FAIL single_dout: got %h tout %b expected %h tout 0", DOUT, TOUT, c);
    end
    n_chk++; if (rises !== NBIT || viol !== 0) begin
      n_fail++; $display("FAIL single_cf: rises %0d viol %0d expected %0d 0", rises, viol, NBIT);
    end
    for (int i = 0; i < NBIT; i++) begin
      n_chk++; if (rise_at[i] !== BIT_CYC + BIT_CYC * (NBIT - 1 - i)) begin
        n_fail++; $display("FAIL single_cf_time[%0d]: got %0d expected %0d", i, rise_at[i], BIT_CYC + BIT_CYC * (NBIT - 1 - i));
      end
    end
    @(posedge CLK); #1;
    n_chk++; if (BUSY !== 1'b0 || DVALID !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: BUSY=%b DVALID=%b expected 0 0", BUSY, DVALID);
    end
  endtask

  task automatic test_continuous();
    int dv1, dv2;
    code_q.push_back(9'h000); code_q.push_back(9'h1FF);
    @(negedge CLK); EN = 1'b1;
    watch(0, 1000, 200, dv1);
    n_chk++; if (dv1 !== LAT || DOUT !== 9'h000) begin
      n_fail++; $display("FAIL cont_first: dv %0d DOUT %h expected %0d 000", dv1, DOUT, LAT);
    end
    watch(1, 30, 200, dv2);
    n_chk++; if (dv2 !== LAT + 1 || DOUT !== 9'h1FF) begin
      n_fail++; $display("FAIL cont_second: gap %0d DOUT %h expected %0d 1ff", dv2, DOUT, LAT + 1);
    end
    n_chk++; if (low_cyc !== SAMPLE_CYC || viol !== 0) begin
      n_fail++; $display("FAIL cont_sample_low: got %0d viol %0d expected %0d 0", low_cyc, viol, SAMPLE_CYC);
    end
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_decide_timeout();
    int dv;
    logic [NBIT-1:0] c, c2;
    c = NBIT'($urandom) | 9'h008;
    nodec_bit = 3;
    code_q.push_back(c);
    @(negedge CLK); EN = 1'b1;
    watch(0, 0, 300, dv);
    n_chk++; if (dv < 0 || DOUT !== (c & ~9'h008) || TOUT !== 1'b1) begin
      n_fail++; $display("FAIL decide_timeout: dv %0d DOUT %h TOUT %b expected %h 1", dv, DOUT, TOUT, c & ~9'h008);
    end
    nodec_bit = -1;
    @(negedge CLK);
    c2 = NBIT'($urandom);
    code_q.push_back(c2);
    @(negedge CLK); EN = 1'b1;
    watch(0, 0, 200, dv);
    n_chk++; if (dv !== LAT || DOUT !== c2 || TOUT !== 1'b0) begin
      n_fail++; $display("FAIL decide_recover: dv %0d DOUT %h TOUT %b expected %0d %h 0", dv, DOUT, TOUT, LAT, c2);
    end
  endtask

  task automatic test_release_timeout();
    int dv;
    logic [NBIT-1:0] c;
    // Bit 6 is set so the comparator still high at the next CKC rise agrees with the code
    c = NBIT'($urandom) | 9'h040;
    stuck_bit = 7;
    code_q.push_back(c);
    @(negedge CLK); EN = 1'b1;
    watch(0, 0, 300, dv);
    n_chk++; if (dv < 0 || DOUT !== c || TOUT !== 1'b1) begin
      n_fail++; $display("FAIL release_timeout: dv %0d DOUT %h TOUT %b expected %h 1", dv, DOUT, TOUT, c);
    end
    n_chk++; if (rises !== NBIT || viol !== 0) begin
      n_fail++; $display("FAIL release_cf: rises %0d viol %0d expected %0d 0", rises, viol, NBIT);
    end
    stuck_bit = -1;
    @(negedge CLK);
  endtask

  task automatic test_en_drop();
    int dv;
    logic [NBIT-1:0] c;
    c = NBIT'($urandom);
    code_q.push_back(c);
    @(negedge CLK); EN = 1'b1;
    watch(0, SAMPLE_CYC + BIT_CYC * 4 + 2, 200, dv);
    n_chk++; if (dv !== LAT || DOUT !== c || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL en_drop_done: dv %0d DOUT %h BUSY %b expected %0d %h 1", dv, DOUT, BUSY, LAT, c);
    end
    @(posedge CLK); #1;
    n_chk++; if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL en_drop_busy: got %b expected 0", BUSY);
    end
    watch(0, 0, 100, dv);
    n_chk++; if (dv !== -1) begin
      n_fail++; $display("FAIL en_drop_extra: dv %0d expected -1", dv);
    end
  endtask

  task automatic test_random();
    int dv, nb;
    logic [NBIT-1:0] c, exp_code;
    for (int t = 0; t < 4; t++) begin
      c  = NBIT'($urandom);
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NBIT - 1)) : -1;
      exp_code = c;
      if (nb >= 0) exp_code[nb] = 1'b0;
      nodec_bit = nb;
      code_q.push_back(c);
      @(negedge CLK); EN = 1'b1;
      watch(0, 0, 300, dv);
      n_chk++; if (dv < 0 || DOUT !== exp_code || TOUT !== (nb >= 0)) begin
        n_fail++; $display("FAIL random[%0d]: DOUT %h TOUT %b expected %h %b", t, DOUT, TOUT, exp_code, nb >= 0);
      end
      nodec_bit = -1;
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_single(9'h15A);
    test_single(NBIT'($urandom));
    test_continuous();
    test_decide_timeout();
    test_release_timeout();
    test_en_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
